ps2_scan_ctrl: RTL and testbench

PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

---
 rtl/ps2_pkg.sv | 48 ++++
 rtl/ps2_evt_fifo.sv | 62 ++++++
 rtl/ps2_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code controller.
// Holds the decoder state enum, protocol byte values, the event record and the game-key lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_BAT  = 8'hAA;
    localparam logic [7:0] PS2_ACK  = 8'hFA;
    localparam logic [7:0] PS2_ECHO = 8'hEE;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // One-hot bit of key_held owned by a decoded key, zero for keys we do not track.
    function automatic logic [7:0] ps2_key_mask(input logic ext, input logic [7:0] code);
        logic [7:0] mask;
        mask = 8'h00;
        if (!ext) begin
            case (code)
                8'h1D:   mask = 8'h01;
                8'h1C:   mask = 8'h02;
                8'h1B:   mask = 8'h04;
                8'h23:   mask = 8'h08;
                default: mask = 8'h00;
            endcase
        end else begin
            case (code)
                8'h75:   mask = 8'h10;
                8'h6B:   mask = 8'h20;
                8'h72:   mask = 8'h40;
                8'h74:   mask = 8'h80;
                default: mask = 8'h00;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO with valid/ready pop side and a push port that reports full.
// Head outputs read as zero while empty so reset leaves the event bus at zero.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  ps2_evt_t push_data,
    output logic     full,
    output logic     pop_valid,
    input  logic     pop_ready,
    output ps2_evt_t pop_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    ps2_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == DEPTH_CNT);
    assign pop_valid = (count != '0);
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign do_pop  = pop_valid && pop_ready;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into events queued in ps2_evt_fifo.
// Define PS2_KEYMAP_EN to track held game keys on key_held; otherwise key_held is tied to zero.
module ps2_scan_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       frame_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       err,
    output logic       ovf,
    output logic [7:0] key_held
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    ps2_state_e    state;
    ps2_state_e    state_nxt;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          push;
    logic          push_ext;
    logic          push_brk;
    logic          fault;
    logic          fifo_full;
    logic          drop;
    ps2_evt_t      push_evt;
    ps2_evt_t      head_evt;

    assign to_hit = !byte_valid && !frame_err && (state != ST_IDLE) && (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_ext  = 1'b0;
        push_brk  = 1'b0;
        fault     = 1'b0;
        if (frame_err) begin
            state_nxt = ST_IDLE;
            fault     = 1'b1;
        end else if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (byte_data == PS2_BRK) begin
                        state_nxt = ST_BRK;
                    end else if (byte_data == PS2_BAT || byte_data == PS2_ACK ||
                                 byte_data == PS2_ECHO) begin
                        state_nxt = ST_IDLE;
                    end else if (byte_data == 8'h00 || byte_data == 8'hFF) begin
                        fault = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_data == PS2_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (byte_data != PS2_EXT) begin
                        push      = 1'b1;
                        push_ext  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    // A second prefix after F0 is a malformed sequence from the device.
                    if (byte_data == PS2_EXT || byte_data == PS2_BRK) begin
                        fault = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_ext = (state == ST_EXT_BRK);
                        push_brk = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (to_hit) begin
            state_nxt = ST_IDLE;
            fault     = 1'b1;
        end
    end

    assign push_evt = '{ext: push_ext, brk: push_brk, code: byte_data};
    assign drop     = push && fifo_full && !(evt_valid && evt_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
            err    <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= fault;
            if (drop) begin
                ovf <= 1'b1;
            end
            if (byte_valid || state == ST_IDLE || to_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_evt),
        .full     (fifo_full),
        .pop_valid(evt_valid),
        .pop_ready(evt_ready),
        .pop_data (head_evt)
    );

    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_break = head_evt.brk;

`ifdef PS2_KEYMAP_EN
    logic [7:0] key_mask;
    logic [7:0] key_held_r;

    assign key_mask = ps2_key_mask(push_evt.ext, push_evt.code);

    // Tracks decoded key state, not FIFO contents, so a dropped event still updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_held_r <= 8'h00;
        end else if (push && key_mask != 8'h00) begin
            if (push_evt.brk) begin
                key_held_r <= key_held_r & ~key_mask;
            end else begin
                key_held_r <= key_held_r | key_mask;
            end
        end
    end

    assign key_held = key_held_r;
`else
    assign key_held = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl: vector table of single bytes plus hand sequences.
module tb_ps2_scan_ctrl;

`ifdef PS2_KEYMAP_EN
    localparam bit KM = 1'b1;
`else
    localparam bit KM = 1'b0;
`endif

    typedef struct packed {
        logic       bv;
        logic [7:0] data;
        logic       ferr;
        logic       ev;
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic       err;
        logic [7:0] keys;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       err;
    logic       ovf;
    logic [7:0] key_held;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    ps2_scan_ctrl #(
        .FIFO_DEPTH (4),
        .TIMEOUT_CYC(25000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .err       (err),
        .ovf       (ovf),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic bv, input logic [7:0] d, input logic fe, input logic ev,
                       input logic x, input logic b, input logic [7:0] c, input logic e,
                       input logic [7:0] k);
        vec_t v;
        v = '{bv: bv, data: d, ferr: fe, ev: ev, ext: x, brk: b, code: c, err: e, keys: k};
        tbl.push_back(v);
    endtask

    // Drive one cycle of input starting at a falling edge; returns at the next falling edge.
    task automatic send(input logic bv, input logic [7:0] d, input logic fe);
        byte_valid = bv;
        byte_data  = d;
        frame_err  = fe;
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        frame_err  = 1'b0;
    endtask

    task automatic chk_head(input string nm, input logic x, input logic b, input logic [7:0] c);
        chk({nm, "_valid"}, {31'd0, evt_valid}, 32'd1);
        chk({nm, "_evt"}, {22'd0, evt_ext, evt_break, evt_code}, {22'd0, x, b, c});
    endtask

    initial begin
        int err_seen;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        frame_err  = 1'b0;
        evt_ready  = 1'b1;

        //      bv  data  fe ev x  b  code  err keys
        add(1, 8'h1D, 0, 1, 0, 0, 8'h1D, 0, 8'h01);
        add(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 8'h01);
        add(1, 8'h1D, 0, 1, 0, 1, 8'h1D, 0, 8'h00);
        add(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(1, 8'h75, 0, 1, 1, 0, 8'h75, 0, 8'h10);
        add(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 8'h10);
        add(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 8'h10);
        add(1, 8'h75, 0, 1, 1, 1, 8'h75, 0, 8'h00);
        add(1, 8'hAA, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(1, 8'hFA, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(1, 8'hEE, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h00);
        add(1, 8'hFF, 0, 0, 0, 0, 8'h00, 1, 8'h00);
        add(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
        add(1, 8'hE0, 0, 0, 0, 0, 8'h00, 1, 8'h00);
        add(1, 8'h1C, 0, 1, 0, 0, 8'h1C, 0, 8'h02);
        add(1, 8'hF0, 1, 0, 0, 0, 8'h00, 1, 8'h02);
        add(1, 8'h1B, 0, 1, 0, 0, 8'h1B, 0, 8'h06);
        add(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 8'h06);
        add(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 8'h06);
        add(1, 8'h72, 0, 1, 0, 0, 8'h72, 0, 8'h06);
        add(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 8'h06);
        add(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 8'h06);
        add(1, 8'h6B, 0, 1, 1, 0, 8'h6B, 0, 8'h26);
        add(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 8'h26);
        add(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 8'h26);
        add(1, 8'hF0, 0, 0, 0, 0, 8'h00, 1, 8'h26);
        add(1, 8'h23, 0, 1, 0, 0, 8'h23, 0, 8'h2E);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h2E);

        #1;
        chk("rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("rst_evt", {22'd0, evt_ext, evt_break, evt_code}, 32'd0);
        chk("rst_err_ovf", {30'd0, err, ovf}, 32'd0);
        chk("rst_keys", {24'd0, key_held}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: evt_ready held high, so each event is popped while the next byte arrives.
        foreach (tbl[i]) begin
            send(tbl[i].bv, tbl[i].data, tbl[i].ferr);
            chk($sformatf("v%0d_valid", i), {31'd0, evt_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_evt", i), {22'd0, evt_ext, evt_break, evt_code},
                tbl[i].ev ? {22'd0, tbl[i].ext, tbl[i].brk, tbl[i].code} : 32'd0);
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
            chk($sformatf("v%0d_keys", i), {24'd0, key_held}, KM ? {24'd0, tbl[i].keys} : 32'd0);
        end
        chk("ovf_clear", {31'd0, ovf}, 32'd0);

        // Timeout after a lone E0, then a plain make code decodes from IDLE.
        send(1, 8'hE0, 0);
        err_seen = 0;
        for (int c = 0; c < 25001; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (err) err_seen++;
        end
        chk("timeout_err_pulses", err_seen, 32'd1);
        send(1, 8'h1C, 0);
        chk_head("timeout_1C", 1'b0, 1'b0, 8'h1C);

        // Reset mid-sequence with an event queued and keys held.
        evt_ready = 1'b0;
        send(1, 8'h1D, 0);
        send(1, 8'hE0, 0);
        chk_head("pre_rst_head", 1'b1 == 1'b0, 1'b0, 8'h1C);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
        chk("mid_rst_evt", {22'd0, evt_ext, evt_break, evt_code}, 32'd0);
        chk("mid_rst_keys", {24'd0, key_held}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        @(negedge clk);
        send(1, 8'h23, 0);
        chk_head("post_rst_23", 1'b0, 1'b0, 8'h23);
        chk("post_rst_keys", {24'd0, key_held}, KM ? 32'h08 : 32'd0);
        send(0, 8'h00, 0);

        // Overflow: five makes with no consumer, the fifth is dropped.
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(1, 8'h15 + 8'(k), 0);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk_head("ovf_head", 1'b0, 1'b0, 8'h15);
        send(0, 8'h00, 0);
        chk_head("ovf_hold", 1'b0, 1'b0, 8'h15);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_head($sformatf("drain%0d", k), 1'b0, 1'b0, 8'h15 + 8'(k));
            @(posedge clk);
            @(negedge clk);
        end
        chk("drain_empty", {31'd0, evt_valid}, 32'd0);

        // Full FIFO accepts a push when a pop happens in the same cycle.
        evt_ready = 1'b0;
        send(1, 8'h21, 0);
        send(1, 8'h22, 0);
        send(1, 8'h24, 0);
        send(1, 8'h26, 0);
        chk_head("full_head", 1'b0, 1'b0, 8'h21);
        evt_ready = 1'b1;
        send(1, 8'h29, 0);
        chk_head("fullpop_0", 1'b0, 1'b0, 8'h22);
        @(posedge clk);
        @(negedge clk);
        chk_head("fullpop_1", 1'b0, 1'b0, 8'h24);
        @(posedge clk);
        @(negedge clk);
        chk_head("fullpop_2", 1'b0, 1'b0, 8'h26);
        @(posedge clk);
        @(negedge clk);
        chk_head("fullpop_3", 1'b0, 1'b0, 8'h29);
        @(posedge clk);
        @(negedge clk);
        chk("fullpop_empty", {31'd0, evt_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
